card_dealer: RTL
================

Name: card_dealer

Overview:
- Upstream card source for the blackjack game core; supplies one card per request from a single 52-card deck.
- Tracks which cards have been dealt, so no card repeats until the deck is reshuffled.
- Draws a pseudo-random card from a free-running LFSR, then probes linearly past already-used cards.
- Outputs the card's rank, suit and blackjack point value for the core's scoring logic.

Parameters:
SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
req  input  1  single-cycle card request; accepted only in IDLE
shuffle  input  1  single-cycle pulse; returns all 52 cards to the deck
card_valid  output  1  one-cycle pulse; card_* outputs hold a new card
card_rank  output  4  1..13 (1=ace, 11=J, 12=Q, 13=K)
card_suit  output  2  0..3
card_value  output  6  blackjack value: ace=11, 2..10 = face value, J/Q/K=10
cards_left  output  6  undealt cards, 0..52
deck_empty  output  1  high when cards_left==0
busy  output  1  high while not in IDLE

Behaviour:
- Reset (async, active-high) values:
  - State IDLE; used mask all 0; cards_left=52; lfsr=SEED.
  - card_valid=0, card_rank=0, card_suit=0, card_value=0, deck_empty=0, busy=0.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; shifts left every cycle, feedback into bit 0.
  - Reset restores SEED; shuffle does not touch it.
- Card index mapping, idx 0..51:
  - suit = idx/13.
  - rank = idx%13 + 1.
  - value = 11 if rank==1, 10 if rank>=10, otherwise rank.
- State IDLE:
  - Triggered when req=1, shuffle=0 and cards_left!=0.
  - Then ptr <= lfsr mod 52, sampled in the accept cycle, and state goes to SEARCH.
  - req while cards_left==0 is ignored; no card_valid; state stays IDLE.
- State SEARCH, one probe per cycle:
  - If used[ptr]=1: ptr <= (ptr==51) ? 0 : ptr+1.
  - Else:
    - Set used[ptr] and decrement cards_left.
    - Register card_rank, card_suit and card_value from ptr.
    - Go to DELIVER.
- State DELIVER:
  - card_valid=1 for exactly this cycle, then back to IDLE.
- Latency:
  - Accept in cycle T; card_valid in cycle T+2 at minimum.
  - Maximum is T+53; a free card is guaranteed because cards_left>0 at accept.
- Card output hold:
  - card_rank, card_suit and card_value hold their value until the next delivery or reset.
  - shuffle does not clear them.
- shuffle:
  - Clears the used mask and sets cards_left=52 next cycle; state goes to IDLE.
  - From SEARCH: the search is aborted, no card is marked, no card_valid.
  - In the DELIVER cycle: card_valid still pulses, and the card counts as dealt before the shuffle.
  - With req in the same cycle: shuffle wins and req is dropped.
- req while busy=1 is ignored; requests are not queued.
- deck_empty is combinational from cards_left==0.
- Reset mid-SEARCH or mid-DELIVER: immediate return to reset values; no card_valid.

Test Plan:
- Reset, then a single req:
  - card_valid exactly once, 2..53 cycles later.
  - cards_left 52->51.
  - Check card_rank/card_suit/card_value against the index mapping.
  - Check card_value = 11 when card_rank=1, and 10 when card_rank in {10..13}.
- Mapping corner cases, with a mask or force used to steer ptr:
  - idx 0 -> rank 1, suit 0, value 11.
  - idx 12 -> rank 13, suit 0, value 10.
  - idx 22 -> rank 10, suit 1, value 10.
  - idx 51 -> rank 13, suit 3, value 10.
- Full deck, 52 sequential reqs:
  - 52 card_valid pulses, all (suit,rank) pairs distinct.
  - cards_left reaches 0 and deck_empty=1.
  - 53rd req -> no card_valid, busy stays 0.
- Wrap-around probe:
  - Deal until only idx 0 is free and the start index is 51.
  - Card is idx 0 (rank 1, suit 0).
- Shuffle during SEARCH:
  - No card_valid, cards_left=52.
  - The next req delivers normally.
- Simultaneous req+shuffle in IDLE with 10 cards left:
  - cards_left=52, busy stays 0, no card_valid.
- Async reset asserted mid-SEARCH:
  - Outputs at reset values immediately, no card_valid.
  - lfsr=8'hA5 on release.

Source files
------------

// File: rtl/card_dealer.sv
`default_nettype none
// ============================================================================
//  Module      : card_dealer
//  Description : Single-deck card source; LFSR start point plus linear probe
//                over a 52-bit used mask, one card per accepted request.
//  Revision    : 1.0 - initial release
// ============================================================================
module card_dealer #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       shuffle,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic [5:0] card_value,
    output logic [5:0] cards_left,
    output logic       deck_empty,
    output logic       busy
);

    localparam logic [5:0] c_deck_size = 6'd52;
    localparam logic [5:0] c_last_idx  = 6'd51;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEARCH  = 2'd1,
        S_DELIVER = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_lfsr;
    logic [51:0] r_used;
    logic [5:0]  r_ptr;
    logic [5:0]  r_cards_left;
    logic [3:0]  r_rank;
    logic [1:0]  r_suit;
    logic [5:0]  r_value;

    logic        w_lfsr_fb;
    logic [5:0]  w_start;
    logic        w_accept;
    logic        w_ptr_used;
    logic [5:0]  w_ptr_inc;
    logic [1:0]  w_suit;
    logic [3:0]  w_rank_m1;
    logic [3:0]  w_rank;
    logic [5:0]  w_value;

    // Fibonacci taps 8,6,5,4 (bits 7,5,4,3)
    assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_start    = 6'(r_lfsr % 8'd52);
    assign w_accept   = (r_state == S_IDLE) && req && !shuffle && (r_cards_left != 6'd0);
    assign w_ptr_used = r_used[r_ptr];
    assign w_ptr_inc  = (r_ptr == c_last_idx) ? 6'd0 : r_ptr + 6'd1;

    // Index to suit/rank without a divider: ptr is always below 52
    always_comb begin
        w_suit    = 2'd0;
        w_rank_m1 = r_ptr[3:0];
        if (r_ptr >= 6'd39) begin
            w_suit    = 2'd3;
            w_rank_m1 = 4'(r_ptr - 6'd39);
        end else if (r_ptr >= 6'd26) begin
            w_suit    = 2'd2;
            w_rank_m1 = 4'(r_ptr - 6'd26);
        end else if (r_ptr >= 6'd13) begin
            w_suit    = 2'd1;
            w_rank_m1 = 4'(r_ptr - 6'd13);
        end
    end

    assign w_rank  = w_rank_m1 + 4'd1;
    assign w_value = (w_rank == 4'd1)  ? 6'd11 :
                     (w_rank >= 4'd10) ? 6'd10 : {2'b00, w_rank};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_next = S_SEARCH;
            S_SEARCH:  if (!w_ptr_used) w_state_next = S_DELIVER;
            S_DELIVER: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
        if (shuffle) begin
            w_state_next = S_IDLE;
        end
    end

    // Shuffle outranks both accept and the probe, so an aborted search marks nothing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr       <= SEED;
            r_used       <= '0;
            r_ptr        <= '0;
            r_cards_left <= c_deck_size;
            r_rank       <= '0;
            r_suit       <= '0;
            r_value      <= '0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
            if (shuffle) begin
                r_used       <= '0;
                r_cards_left <= c_deck_size;
            end else if (w_accept) begin
                r_ptr <= w_start;
            end else if (r_state == S_SEARCH) begin
                if (w_ptr_used) begin
                    r_ptr <= w_ptr_inc;
                end else begin
                    r_used[r_ptr] <= 1'b1;
                    r_cards_left  <= r_cards_left - 6'd1;
                    r_rank        <= w_rank;
                    r_suit        <= w_suit;
                    r_value       <= w_value;
                end
            end
        end
    end

    assign card_valid = (r_state == S_DELIVER);
    assign busy       = (r_state != S_IDLE);
    assign card_rank  = r_rank;
    assign card_suit  = r_suit;
    assign card_value = r_value;
    assign cards_left = r_cards_left;
    assign deck_empty = (r_cards_left == 6'd0);

endmodule
`default_nettype wire
